exec_stage: RTL

Decode, register-file and ALU stage that consumes the 20-bit instruction word from the fetch stage and executes it. It latches the instruction each cycle, reads four 8-bit registers R1–R4, and executes one ALU operation per instruction in a two-stage ID/EX pipeline. It drives the fetch stage's `hold` input to stall on read-after-write hazards when forwarding is disabled.

---
 rtl/exec_pkg.sv | 83 ++++++++
 rtl/exec_stage_if.sv | 30 +++
 rtl/exec_stage_alu8.sv | 41 ++++
 rtl/exec_stage.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exec_pkg
// Description : Shared definitions for the exec_stage ID/EX pipeline:
//               instruction field positions, opcodes, flag indices and a
//               small opcode decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package exec_pkg;

    localparam int DATA_W   = 8;
    localparam int REG_AW   = 2;
    localparam int NUM_REGS = 4;
    localparam int INSTR_W  = 20;
    localparam int OP_W     = 4;
    localparam int FLAG_W   = 3;

    // Instruction field bit positions
    localparam int OP_MSB  = 19;
    localparam int OP_LSB  = 16;
    localparam int RD_MSB  = 9;
    localparam int RD_LSB  = 8;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Opcodes
    localparam logic [OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] OP_ADDI = 4'b0011;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0100;
    localparam logic [OP_W-1:0] OP_SUBI = 4'b0101;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b1000;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b1010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b1100;
    localparam logic [OP_W-1:0] OP_AND  = 4'b1110;

    // Flag bit indices within {c,n,z}
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Per-opcode control bits produced by the ID stage
    typedef struct packed {
        logic legal;    // defined opcode (nop included)
        logic writes;   // writes rd at the EX edge
        logic rd_rd;    // reads register rd
        logic rd_rs;    // reads register rs
        logic use_imm;  // operand B is the immediate
    } decode_t;

    function automatic decode_t decode_op(input logic [OP_W-1:0] op);
        decode_t d;
        d = '0;
        case (op)
            OP_NOP: begin
                d.legal = 1'b1;
            end
            OP_ADD, OP_SUB, OP_XOR, OP_OR, OP_AND: begin
                d.legal  = 1'b1;
                d.writes = 1'b1;
                d.rd_rd  = 1'b1;
                d.rd_rs  = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                d.legal   = 1'b1;
                d.writes  = 1'b1;
                d.rd_rd   = 1'b1;
                d.use_imm = 1'b1;
            end
            OP_NOT: begin
                d.legal  = 1'b1;
                d.writes = 1'b1;
                d.rd_rd  = 1'b1;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exec_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : exec_stage_if
// Description : Fetch-side and writeback/observation signals of exec_stage.
//               master = fetch/observer side, slave = exec_stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface exec_stage_if;
    import exec_pkg::*;

    logic [INSTR_W-1:0]           instruction;
    logic                         hold;
    logic                         wb_valid;
    logic [REG_AW-1:0]            wb_addr;
    logic [DATA_W-1:0]            wb_data;
    logic [FLAG_W-1:0]            flags;
    logic                         illegal;
    logic [NUM_REGS*DATA_W-1:0]   regs_flat;

    modport master (
        output instruction,
        input  hold, wb_valid, wb_addr, wb_data, flags, illegal, regs_flat
    );

    modport slave (
        input  instruction,
        output hold, wb_valid, wb_addr, wb_data, flags, illegal, regs_flat
    );
endinterface
`default_nettype wire

// File: rtl/exec_stage_alu8.sv
`default_nettype none
// ============================================================================
// Module      : alu8
// Description : Combinational 8-bit ALU. c is the carry for add/addi, the
//               borrow for sub/subi and 0 for logic ops.
// Revision    : 1.0 - initial release
// ============================================================================
module alu8
    import exec_pkg::*;
(
    input  wire logic [OP_W-1:0]   i_op,
    input  wire logic [DATA_W-1:0] i_a,
    input  wire logic [DATA_W-1:0] i_b,
    output logic      [DATA_W-1:0] o_result,
    output logic                   o_c
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // The 9th bit of the widened difference is set exactly when a < b
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Select result and carry/borrow by opcode
    always_comb begin
        o_result = '0;
        o_c      = 1'b0;
        case (i_op)
            OP_ADD, OP_ADDI: {o_c, o_result} = w_sum;
            OP_SUB, OP_SUBI: {o_c, o_result} = w_diff;
            OP_NOT:          o_result = ~i_a;
            OP_XOR:          o_result = i_a ^ i_b;
            OP_OR:           o_result = i_a | i_b;
            OP_AND:          o_result = i_a & i_b;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : exec_stage
// Description : IR latch, ID (decode + register read) and EX (ALU +
//               writeback) stages over a four-entry 8-bit register file.
//               RAW hazards are either bypassed from EX (FORWARD=1) or
//               resolved by a one-cycle hold with a bubble (FORWARD=0).
// Revision    : 1.0 - initial release
// ============================================================================
module exec_stage
    import exec_pkg::*;
#(
    parameter bit FORWARD = 1'b0
) (
    input  wire logic   clk,
    input  wire logic   reset_n,
    exec_stage_if.slave bus
);

    logic [INSTR_W-1:0] r_ir;
    logic [DATA_W-1:0]  r_rf [NUM_REGS];
    logic [FLAG_W-1:0]  r_flags;

    logic               r_ex_valid;
    logic               r_ex_ill;
    logic [OP_W-1:0]    r_ex_op;
    logic [REG_AW-1:0]  r_ex_rd;
    logic [DATA_W-1:0]  r_ex_a;
    logic [DATA_W-1:0]  r_ex_b;

    logic [OP_W-1:0]    w_op;
    logic [REG_AW-1:0]  w_rd;
    logic [REG_AW-1:0]  w_rs;
    logic [DATA_W-1:0]  w_imm;
    decode_t            w_dec;
    logic               w_hit_rd;
    logic               w_hit_rs;
    logic               w_hazard;
    logic               w_hold;
    logic               w_fwd_rd;
    logic               w_fwd_rs;
    logic [DATA_W-1:0]  w_opa;
    logic [DATA_W-1:0]  w_rs_val;
    logic [DATA_W-1:0]  w_opb;
    logic [DATA_W-1:0]  w_alu_res;
    logic               w_alu_c;
    logic               w_unused;

    // ID decode of the latched instruction
    assign w_op  = r_ir[OP_MSB:OP_LSB];
    assign w_rd  = r_ir[RD_MSB:RD_LSB];
    assign w_rs  = r_ir[RS_MSB:RS_LSB];
    assign w_imm = r_ir[IMM_MSB:IMM_LSB];
    assign w_dec = decode_op(w_op);

    // Bits between op and rd carry no meaning
    assign w_unused = ^r_ir[OP_LSB-1:RD_MSB+1];

    // RAW detection against the instruction currently in EX; flop-driven only
    assign w_hit_rd = r_ex_valid && (w_rd == r_ex_rd);
    assign w_hit_rs = r_ex_valid && (w_rs == r_ex_rd);
    assign w_hazard = (w_dec.rd_rd && w_hit_rd) || (w_dec.rd_rs && w_hit_rs);

    generate
        if (FORWARD) begin : g_bypass
            assign w_hold   = 1'b0;
            assign w_fwd_rd = w_hit_rd;
            assign w_fwd_rs = w_hit_rs;
        end else begin : g_stall
            assign w_hold   = w_hazard;
            assign w_fwd_rd = 1'b0;
            assign w_fwd_rs = 1'b0;
        end
    endgenerate

    // Operand muxes: register file or the EX result being written this cycle
    assign w_opa    = w_fwd_rd ? w_alu_res : r_rf[w_rd];
    assign w_rs_val = w_fwd_rs ? w_alu_res : r_rf[w_rs];
    assign w_opb    = w_dec.use_imm ? w_imm : w_rs_val;

    alu8 u_alu (
        .i_op     (r_ex_op),
        .i_a      (r_ex_a),
        .i_b      (r_ex_b),
        .o_result (w_alu_res),
        .o_c      (w_alu_c)
    );

    // IR latch; frozen while the ID instruction waits on a hazard
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ir <= '0;
        end else if (!w_hold) begin
            r_ir <= bus.instruction;
        end
    end

    // ID -> EX registers; a stall inserts a bubble
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ex_valid <= 1'b0;
            r_ex_ill   <= 1'b0;
            r_ex_op    <= OP_NOP;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else if (w_hold) begin
            r_ex_valid <= 1'b0;
            r_ex_ill   <= 1'b0;
            r_ex_op    <= OP_NOP;
            r_ex_rd    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
        end else begin
            r_ex_valid <= w_dec.writes;
            r_ex_ill   <= !w_dec.legal;
            r_ex_op    <= w_dec.writes ? w_op : OP_NOP;
            r_ex_rd    <= w_rd;
            r_ex_a     <= w_opa;
            r_ex_b     <= w_opb;
        end
    end

    // EX writeback into the register file and flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_rf[i] <= '0;
            end
            r_flags <= '0;
        end else if (r_ex_valid) begin
            r_rf[r_ex_rd]   <= w_alu_res;
            r_flags[FLAG_C] <= w_alu_c;
            r_flags[FLAG_N] <= w_alu_res[DATA_W-1];
            r_flags[FLAG_Z] <= (w_alu_res == '0);
        end
    end

    assign bus.hold      = w_hold;
    assign bus.wb_valid  = r_ex_valid;
    assign bus.wb_addr   = r_ex_rd;
    assign bus.wb_data   = w_alu_res;
    assign bus.flags     = r_flags;
    assign bus.illegal   = r_ex_ill;
    assign bus.regs_flat = {r_rf[3], r_rf[2], r_rf[1], r_rf[0]};

endmodule
`default_nettype wire
